// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares one data-memory port between the CPU load/store unit and a DMA port,
// with alignment checking, byte-lane steering and a fixed-latency access sequencer.
module dm_access_arbiter #(
    parameter int MEM_LAT        = 1,
    parameter int CPU_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_size,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp_err,
    input  logic        dma_req_valid,
    output logic        dma_req_ready,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [2:0]  dma_size,
    output logic        dma_resp_valid,
    output logic [31:0] dma_rdata,
    output logic        dma_resp_err,
    output logic        mem_en,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  rd_type,
    output logic [1:0]  rd_addr_low
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [7:0] SMAX = 8'(CPU_STREAK_MAX);
    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
    state_t      state;
    logic [7:0]  streak;
    logic [2:0]  cnt;
    logic        owner;
    logic        we_q;
    logic [2:0]  size_q;
    logic [1:0]  low_q;
    logic        dma_win;
    logic        cpu_win;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_size;
    logic        is_half;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] rd_word;
    always_comb begin
        dma_win = dma_req_valid && (!cpu_req_valid || streak == SMAX);
        cpu_win = cpu_req_valid && !dma_win;
        s_we    = dma_win ? dma_we    : cpu_we;
        s_addr  = dma_win ? dma_addr  : cpu_addr;
        s_wdata = dma_win ? dma_wdata : cpu_wdata;
        s_size  = dma_win ? dma_size  : cpu_size;
        is_half = s_size == 3'd3 || s_size == 3'd4;
        legal   = s_size == 3'd0 ? s_addr[1:0] == 2'b00 : is_half ? !s_addr[0] : s_size <= 3'd2;
        be      = s_size == 3'd0 ? 4'hf : is_half ? 4'h3 << s_addr[1:0] : 4'h1 << s_addr[1:0];
        lanes   = s_size == 3'd0 ? s_wdata : is_half ? {2{s_wdata[15:0]}} : {4{s_wdata[7:0]}};
        rd_word = we_q ? 32'd0 : mem_rdata;
    end
    // Ready is masked by reset so every output reads 0 while reset is held.
    assign cpu_req_ready = reset && state == IDLE && cpu_win;
    assign dma_req_ready = reset && state == IDLE && dma_win;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            streak         <= '0;
            cnt            <= '0;
            owner          <= 1'b0;
            we_q           <= 1'b0;
            size_q         <= '0;
            low_q          <= '0;
            mem_en         <= 1'b0;
            mem_be         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            cpu_resp_valid <= 1'b0;
            dma_resp_valid <= 1'b0;
            cpu_resp_err   <= 1'b0;
            dma_resp_err   <= 1'b0;
            cpu_rdata      <= '0;
            dma_rdata      <= '0;
            rd_type        <= '0;
            rd_addr_low    <= '0;
        end else begin
            if (!dma_req_valid || dma_req_ready)
                streak <= '0;
            else if (cpu_req_ready && streak != SMAX)
                streak <= streak + 8'd1;
            mem_en         <= 1'b0;
            mem_be         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            cpu_resp_valid <= 1'b0;
            dma_resp_valid <= 1'b0;
            cpu_resp_err   <= 1'b0;
            dma_resp_err   <= 1'b0;
            cpu_rdata      <= '0;
            dma_rdata      <= '0;
            case (state)
                IDLE: if (cpu_win || dma_win) begin
                    owner  <= dma_win;
                    we_q   <= s_we;
                    size_q <= s_size;
                    low_q  <= s_addr[1:0];
                    cnt    <= '0;
                    if (legal) begin
                        state     <= ACCESS;
                        mem_en    <= 1'b1;
                        mem_be    <= s_we ? be : 4'h0;
                        mem_wdata <= s_we ? lanes : 32'd0;
                        mem_addr  <= {s_addr[31:2], 2'b00};
                    end else begin
                        // Illegal requests skip the memory entirely and answer with an error.
                        state          <= RESP;
                        cpu_resp_valid <= !dma_win;
                        dma_resp_valid <= dma_win;
                        cpu_resp_err   <= !dma_win;
                        dma_resp_err   <= dma_win;
                        if (!s_we) begin
                            rd_type     <= s_size;
                            rd_addr_low <= s_addr[1:0];
                        end
                    end
                end
                ACCESS: if (cnt == LAST) begin
                    state          <= RESP;
                    cpu_resp_valid <= !owner;
                    dma_resp_valid <= owner;
                    cpu_rdata      <= owner ? 32'd0 : rd_word;
                    dma_rdata      <= owner ? rd_word : 32'd0;
                    if (!we_q) begin
                        rd_type     <= size_q;
                        rd_addr_low <= low_q;
                    end
                end else begin
                    cnt <= cnt + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: random CPU/DMA traffic against a transaction-level model of
// arbitration, alignment, lane steering, access timing and a reset abort.
module tb_dm_access_arbiter;
    localparam int L = 3;
    localparam int SMAX = 4;
    logic        clk = 0;
    logic        reset = 0;
    logic        cpu_v = 0, cpu_we = 0, dma_v = 0, dma_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wd = 0, dma_addr = 0, dma_wd = 0, mem_rdata = 0;
    logic [2:0]  cpu_size = 0, dma_size = 0;
    logic        cpu_req_ready, cpu_resp_valid, cpu_resp_err;
    logic        dma_req_ready, dma_resp_valid, dma_resp_err, mem_en;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  rd_type;
    logic [1:0]  rd_addr_low;
    int total = 0, bad = 0;
    int cyc = 0, next_idle = 0, streak_m = 0, exp_mem_cyc = -1, exp_resp_cyc = -1, cap = -1;
    bit own, cur_we, exp_err, g_cpu, g_dma, quiet = 0, both = 0;
    logic [2:0]  cur_size, rd_type_m = 0;
    logic [1:0]  cur_low, rd_low_m = 0;
    logic [3:0]  exp_be, cap_idx;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [31:0] rmem [16];
    logic [31:0] bmem [16];

    dm_access_arbiter #(.MEM_LAT(L), .CPU_STREAK_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_v), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wd), .cpu_size(cpu_size),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_resp_err(cpu_resp_err),
        .dma_req_valid(dma_v), .dma_req_ready(dma_req_ready), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wd), .dma_size(dma_size),
        .dma_resp_valid(dma_resp_valid), .dma_rdata(dma_rdata), .dma_resp_err(dma_resp_err),
        .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_type(rd_type), .rd_addr_low(rd_addr_low)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk(tag, |{cpu_req_ready, dma_req_ready, cpu_resp_valid, dma_resp_valid, cpu_resp_err,
                   dma_resp_err, cpu_rdata, dma_rdata, mem_en, mem_be, mem_addr, mem_wdata,
                   rd_type, rd_addr_low}, 0);
    endtask

    task automatic grant(input bit d, input bit we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n, off;
        bit legal;
        off = int'(addr[1:0]);
        n = size == 0 ? 4 : size <= 2 ? 1 : size <= 4 ? 2 : 0;
        legal = n != 0 && off % (n == 0 ? 1 : n) == 0;
        own = d; cur_we = we; cur_size = size; cur_low = addr[1:0];
        exp_err = !legal; exp_rd = 0; exp_be = 0; exp_wd = 0;
        exp_addr = addr & ~32'd3;
        if (legal) begin
            exp_mem_cyc = cyc + 1;
            exp_resp_cyc = cyc + 1 + L;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    exp_wd[8*b +: 8] = wd[8*(b % n) +: 8];
                    exp_be[b] = b >= off && b < off + n;
                    if (exp_be[b]) rmem[addr[5:2]][8*b +: 8] = exp_wd[8*b +: 8];
                end
            end else exp_rd = rmem[addr[5:2]];
        end else begin
            exp_mem_cyc = -1;
            exp_resp_cyc = cyc + 1;
        end
        next_idle = exp_resp_cyc + 1;
    endtask

    task automatic eval();
        bit idle, ec, ed, rv;
        idle = cyc >= next_idle;
        ed = idle && dma_v && (!cpu_v || streak_m == SMAX);
        ec = idle && cpu_v && !ed;
        chk("cpu_ready", cpu_req_ready, ec);
        chk("dma_ready", dma_req_ready, ed);
        chk("mem_en", mem_en, cyc == exp_mem_cyc);
        if (cyc == exp_mem_cyc) begin
            chk("mem_be", mem_be, exp_be);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wd);
        end else chk("mem_quiet", {mem_be, mem_wdata}, 0);
        rv = cyc == exp_resp_cyc;
        chk("cpu_resp_valid", cpu_resp_valid, rv && !own);
        chk("dma_resp_valid", dma_resp_valid, rv && own);
        if (rv) begin
            chk("rdata", own ? dma_rdata : cpu_rdata, exp_rd);
            chk("resp_err", own ? dma_resp_err : cpu_resp_err, exp_err);
            if (!cur_we) begin rd_type_m = cur_size; rd_low_m = cur_low; end
        end
        chk("rd_type", rd_type, rd_type_m);
        chk("rd_addr_low", rd_addr_low, rd_low_m);
        if (mem_en) begin
            cap = cyc + L - 1;
            cap_idx = mem_addr[5:2];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) bmem[cap_idx][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        mem_rdata = cyc == cap ? bmem[cap_idx] : $urandom;
        g_cpu = ec; g_dma = ed;
        if (ed) grant(1, dma_we, dma_size, dma_addr, dma_wd);
        else if (ec) grant(0, cpu_we, cpu_size, cpu_addr, cpu_wd);
        if (!dma_v || ed) streak_m = 0;
        else if (ec && streak_m < SMAX) streak_m++;
    endtask

    task automatic drive();
        if (g_cpu || !cpu_v) begin
            cpu_v = !quiet && (both || $urandom_range(0, 2) != 0);
            cpu_we = 1'($urandom_range(0, 1)); cpu_size = 3'($urandom_range(0, 7));
            cpu_addr = 32'h0001_0000 | 32'($urandom_range(0, 63)); cpu_wd = $urandom;
        end
        if (g_dma || !dma_v) begin
            dma_v = !quiet && (both || $urandom_range(0, 3) == 0);
            dma_we = 1'($urandom_range(0, 1)); dma_size = 3'($urandom_range(0, 7));
            dma_addr = 32'h0001_0000 | 32'($urandom_range(0, 63)); dma_wd = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        drive();
        @(negedge clk);
        eval();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin rmem[i] = $urandom; bmem[i] = rmem[i]; end
        repeat (3) @(negedge clk);
        all_zero("reset_outputs");
        reset = 1;
        eval();
        repeat (1500) step();
        both = 1;
        repeat (80) step();
        both = 0;
        repeat (300) step();
        quiet = 1;
        repeat (20) step();
        @(posedge clk); #1;
        dma_v = 1; dma_we = 1; dma_size = 0; dma_addr = 32'h0001_0010; dma_wd = $urandom;
        @(negedge clk);
        chk("abort_dma_grant", dma_req_ready, 1);
        @(posedge clk); #1;
        chk("abort_mem_en", mem_en, 1);
        dma_v = 0;
        reset = 0;
        cpu_v = 1; cpu_we = 0; cpu_size = 0; cpu_addr = 32'h0001_0020;
        #1 all_zero("abort_async_zero");
        @(negedge clk); @(negedge clk);
        all_zero("abort_held_zero");
        reset = 1;
        cyc = 0; next_idle = 0; streak_m = 0; exp_mem_cyc = -1; exp_resp_cyc = -1; cap = -1;
        rd_type_m = 0; rd_low_m = 0;
        #1 eval();
        chk("abort_cpu_first", g_cpu, 1);
        repeat (10) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
